// File: rtl/conv_layer_input_ctrl.sv
// Sequencer for conv_layer_input_interface: preloads KERNEL_SIZE rows per image, then alternates
// SHIFT/LOAD. It also tracks the interface acks, applies a timeout, and flags rows, done and errors.
module conv_layer_input_ctrl #(
    parameter int unsigned KERNEL_SIZE    = 2,
    parameter int unsigned IMAGE_SIZE     = 8,
    parameter int unsigned ROW_CNT_WIDTH  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TO_WIDTH       = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               ack,
    output logic                     iface_enable,
    output logic [1:0]               cmd,
    output logic                     busy,
    output logic                     row_valid,
    output logic [ROW_CNT_WIDTH-1:0] out_row_idx,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned OUT_ROWS = IMAGE_SIZE - KERNEL_SIZE + 1;

    localparam logic [1:0] ACK_IDLE      = 2'd0;
    localparam logic [1:0] ACK_LOAD_FIN  = 2'd1;
    localparam logic [1:0] ACK_SHIFT_FIN = 2'd2;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_SHIFT = 2'd2;

    localparam logic [ROW_CNT_WIDTH-1:0] LAST_PRELOAD = ROW_CNT_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [ROW_CNT_WIDTH-1:0] LAST_OUT_ROW = ROW_CNT_WIDTH'(OUT_ROWS - 1);
    localparam logic [ROW_CNT_WIDTH-1:0] ROW_ONE      = ROW_CNT_WIDTH'(1);
    localparam logic [TO_WIDTH-1:0]      TO_LAST      = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0]      TO_ONE       = TO_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE_CMD,
        S_PRE_WAIT,
        S_SH_CMD,
        S_SH_WAIT,
        S_LD_CMD,
        S_LD_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                   state, state_nxt;
    logic [ROW_CNT_WIDTH-1:0] load_cnt, load_cnt_nxt;
    logic [ROW_CNT_WIDTH-1:0] out_cnt, out_cnt_nxt;
    logic [TO_WIDTH-1:0]      to_cnt, to_cnt_nxt;
    logic                     row_fin;
    logic                     nxt_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            load_cnt <= '0;
            out_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            load_cnt <= load_cnt_nxt;
            out_cnt  <= out_cnt_nxt;
            to_cnt   <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_cnt_nxt = load_cnt;
        out_cnt_nxt  = out_cnt;
        to_cnt_nxt   = to_cnt;
        row_fin      = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt    = S_PRE_CMD;
                    load_cnt_nxt = '0;
                    out_cnt_nxt  = '0;
                end
            end

            S_PRE_CMD: begin
                to_cnt_nxt = '0;
                state_nxt  = S_PRE_WAIT;
            end

            S_SH_CMD: begin
                to_cnt_nxt = '0;
                state_nxt  = S_SH_WAIT;
            end

            S_LD_CMD: begin
                to_cnt_nxt = '0;
                state_nxt  = S_LD_WAIT;
            end

            S_PRE_WAIT: begin
                if (ack == ACK_LOAD_FIN) begin
                    load_cnt_nxt = load_cnt + ROW_ONE;
                    state_nxt    = (load_cnt == LAST_PRELOAD) ? S_SH_CMD : S_PRE_CMD;
                end else if (ack != ACK_IDLE) begin
                    state_nxt = S_ERROR;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_ERROR;
                end else begin
                    to_cnt_nxt = to_cnt + TO_ONE;
                end
            end

            S_SH_WAIT: begin
                if (ack == ACK_SHIFT_FIN) begin
                    row_fin     = 1'b1;
                    out_cnt_nxt = out_cnt + ROW_ONE;
                    state_nxt   = (out_cnt == LAST_OUT_ROW) ? S_DONE : S_LD_CMD;
                end else if (ack != ACK_IDLE) begin
                    state_nxt = S_ERROR;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_ERROR;
                end else begin
                    to_cnt_nxt = to_cnt + TO_ONE;
                end
            end

            S_LD_WAIT: begin
                if (ack == ACK_LOAD_FIN) begin
                    load_cnt_nxt = load_cnt + ROW_ONE;
                    state_nxt    = S_SH_CMD;
                end else if (ack != ACK_IDLE) begin
                    state_nxt = S_ERROR;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = S_ERROR;
                end else begin
                    to_cnt_nxt = to_cnt + TO_ONE;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign nxt_active = (state_nxt != S_IDLE) && (state_nxt != S_DONE) && (state_nxt != S_ERROR);

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd          <= CMD_IDLE;
            iface_enable <= 1'b0;
            busy         <= 1'b0;
            row_valid    <= 1'b0;
            out_row_idx  <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state_nxt)
                S_PRE_CMD, S_LD_CMD: cmd <= CMD_LOAD;
                S_SH_CMD:            cmd <= CMD_SHIFT;
                default:             cmd <= CMD_IDLE;
            endcase
            iface_enable <= nxt_active;
            busy         <= nxt_active;
            row_valid    <= row_fin;
            if (row_fin) begin
                out_row_idx <= out_cnt;
            end
            done <= (state_nxt == S_DONE) && (state != S_DONE);
            err  <= (state_nxt == S_ERROR);
        end
    end

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// Directed bench for conv_layer_input_ctrl: a behavioural interface model answers commands,
// a vector table covers whole-image runs, and hand sequences cover timing corners.
module tb_conv_layer_input_ctrl;

    localparam int KS   = 2;
    localparam int IMG  = 8;
    localparam int ROWS = IMG - KS + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] ack;
    logic       iface_enable;
    logic [1:0] cmd;
    logic       busy;
    logic       row_valid;
    logic [3:0] out_row_idx;
    logic       done;
    logic       err;

    conv_layer_input_ctrl #(
        .KERNEL_SIZE   (KS),
        .IMAGE_SIZE    (IMG),
        .ROW_CNT_WIDTH (4),
        .TIMEOUT_CYCLES(64),
        .TO_WIDTH      (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ack         (ack),
        .iface_enable(iface_enable),
        .cmd         (cmd),
        .busy        (busy),
        .row_valid   (row_valid),
        .out_row_idx (out_row_idx),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model configuration, written by the main sequence only
    int load_dly   = IMG;
    int shift_dly  = KS * KS + 2;
    int drop_idx   = 0;
    int inject_bad = 0;
    int run_id     = 0;

    // model observations, written by the responder only
    int seen_run = 0;
    int n_load   = 0;
    int n_shift  = 0;
    int n_rows   = 0;
    int n_done   = 0;
    int seq_bad  = 0;
    int pend     = 0;
    logic [1:0] pend_ack = 2'd0;

    typedef struct {
        int load_dly;
        int shift_dly;
        int drop_idx;
        int exp_loads;
        int exp_shifts;
        int exp_rows;
        int exp_done;
        int exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic start_pulse(input bit new_run);
        @(posedge clk);
        #2;
        if (new_run) run_id++;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_end(input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done || err) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Interface model: sees a command in its CMD cycle and answers after the configured delay.
    initial begin
        ack = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 0;
                ack  = 2'd0;
            end else begin
                if (run_id != seen_run) begin
                    seen_run = run_id;
                    n_load = 0; n_shift = 0; n_rows = 0; n_done = 0; seq_bad = 0; pend = 0;
                end
                ack = 2'd0;
                if (row_valid) begin
                    if (int'(out_row_idx) != n_rows) seq_bad++;
                    n_rows++;
                end
                if (done) n_done++;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) ack = pend_ack;
                end
                if (cmd == 2'd1) begin
                    n_load++;
                    if (n_load > KS && n_shift != n_load - KS) seq_bad++;
                    if (inject_bad != 0 && n_load == 1) begin
                        pend = 3; pend_ack = 2'd2;
                    end else if (n_load == drop_idx) begin
                        pend = 0;
                    end else begin
                        pend = load_dly; pend_ack = 2'd1;
                    end
                end else if (cmd == 2'd2) begin
                    if (n_load != n_shift + KS) seq_bad++;
                    n_shift++;
                    pend = shift_dly; pend_ack = 2'd2;
                end
            end
        end
    end

    initial begin
        bit to;
        bit found;

        vecs[0] = '{IMG, KS*KS+2, 0, IMG, ROWS, ROWS, 1, 0};
        vecs[1] = '{64,  64,      0, IMG, ROWS, ROWS, 1, 0};
        vecs[2] = '{1,   1,       0, IMG, ROWS, ROWS, 1, 0};
        vecs[3] = '{IMG, KS*KS+2, 3, 3,   1,    1,    0, 1};
        vecs[4] = '{IMG, 65,      0, 2,   1,    0,    0, 1};
        vecs[5] = '{65,  KS*KS+2, 0, 1,   0,    0,    0, 1};

        rst   = 1'b1;
        start = 1'b0;

        // reset values, held while rst is high
        repeat (3) tick();
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_enable", int'(iface_enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_row_valid", int'(row_valid), 0);
        chk("rst_row_idx", int'(out_row_idx), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        #2 rst = 1'b0;
        tick();
        chk("idle_busy", int'(busy), 0);

        // whole-image runs from the vector table
        for (int v = 0; v < 6; v++) begin
            load_dly  = vecs[v].load_dly;
            shift_dly = vecs[v].shift_dly;
            drop_idx  = vecs[v].drop_idx;
            start_pulse(1'b1);
            chk($sformatf("v%0d_first_cmd", v), int'(cmd), 1);
            chk($sformatf("v%0d_first_enable", v), int'(iface_enable), 1);
            chk($sformatf("v%0d_first_busy", v), int'(busy), 1);
            tick();
            chk($sformatf("v%0d_wait_cmd_idle", v), int'(cmd), 0);
            wait_end(4000, to);
            chk($sformatf("v%0d_end_reached", v), int'(to), 0);
            chk($sformatf("v%0d_loads", v), n_load, vecs[v].exp_loads);
            chk($sformatf("v%0d_shifts", v), n_shift, vecs[v].exp_shifts);
            chk($sformatf("v%0d_rows", v), n_rows, vecs[v].exp_rows);
            chk($sformatf("v%0d_err", v), int'(err), vecs[v].exp_err);
            chk($sformatf("v%0d_seq", v), seq_bad, 0);
            repeat (3) tick();
            chk($sformatf("v%0d_done_count", v), n_done, vecs[v].exp_done);
            chk($sformatf("v%0d_done_pulse", v), int'(done), 0);
            chk($sformatf("v%0d_end_cmd", v), int'(cmd), 0);
            chk($sformatf("v%0d_end_enable", v), int'(iface_enable), 0);
            chk($sformatf("v%0d_end_busy", v), int'(busy), 0);
            chk($sformatf("v%0d_err_held", v), int'(err), vecs[v].exp_err);
        end

        // dropped 3rd LOAD ack: error exactly 64 cycles after LD_WAIT is entered
        load_dly  = IMG;
        shift_dly = KS * KS + 2;
        drop_idx  = 3;
        start_pulse(1'b1);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (cmd == 2'd1 && n_load == 3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("to_ld_cmd_found", int'(found), 1);
        repeat (64) tick();
        chk("to_err_before", int'(err), 0);
        chk("to_busy_before", int'(busy), 1);
        tick();
        chk("to_err_at_64", int'(err), 1);
        chk("to_cmd", int'(cmd), 0);
        chk("to_enable", int'(iface_enable), 0);
        drop_idx = 0;
        start_pulse(1'b1);
        chk("to_recover_err_clr", int'(err), 0);
        wait_end(4000, to);
        chk("to_recover_end", int'(to), 0);
        chk("to_recover_done", int'(done), 1);
        chk("to_recover_rows", n_rows, ROWS);
        chk("to_recover_seq", seq_bad, 0);

        // SHIFT_FIN during PRE_WAIT
        inject_bad = 1;
        start_pulse(1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("inj_ack_seen", int'(found), 1);
        chk("inj_err_before", int'(err), 0);
        tick();
        chk("inj_err_next", int'(err), 1);
        chk("inj_cmd", int'(cmd), 0);
        repeat (5) tick();
        chk("inj_err_sticky", int'(err), 1);
        inject_bad = 0;
        start_pulse(1'b1);
        chk("inj_restart_err_clr", int'(err), 0);
        chk("inj_restart_busy", int'(busy), 1);
        repeat (20) tick();
        start_pulse(1'b0);
        wait_end(4000, to);
        chk("busy_start_end", int'(to), 0);
        chk("busy_start_loads", n_load, IMG);
        chk("busy_start_shifts", n_shift, ROWS);
        chk("busy_start_rows", n_rows, ROWS);
        chk("busy_start_seq", seq_bad, 0);
        chk("busy_start_err", int'(err), 0);

        // reset during the 4th SHIFT
        start_pulse(1'b1);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (cmd == 2'd2 && n_shift == 4) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("rst4_shift_found", int'(found), 1);
        repeat (2) tick();
        chk("rst4_idx_before", int'(out_row_idx), 2);
        #2 rst = 1'b1;
        #1;
        chk("rst4_busy", int'(busy), 0);
        chk("rst4_enable", int'(iface_enable), 0);
        chk("rst4_cmd", int'(cmd), 0);
        chk("rst4_row_idx", int'(out_row_idx), 0);
        tick();
        #2 rst = 1'b0;
        start_pulse(1'b1);
        wait_end(4000, to);
        chk("rst4_rerun_end", int'(to), 0);
        chk("rst4_rerun_loads", n_load, IMG);
        chk("rst4_rerun_rows", n_rows, ROWS);
        chk("rst4_rerun_seq", seq_bad, 0);
        tick();
        chk("rst4_rerun_done", n_done, 1);
        chk("rst4_rerun_err", int'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
